// File: rtl/moore_ssm_sched_pkg.sv
// Shared types for the round-robin 1101-detector scheduler.
// Holds the FSM state encoding and the requester-id width helper.
package moore_ssm_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_SHIFT,
      ST_DRAIN,
      ST_RESP
   } sched_state_t;

   localparam int DEFAULT_NREQ = 4;

   // A single requester would still need one id bit to keep ports legal.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int DEFAULT_ID_W = id_width(DEFAULT_NREQ);

endpackage

// File: rtl/moore_ssm_sched_rr_arbiter.sv
// Rotating-priority arbiter: picks the first active request at or after ptr,
// wrapping upward, and reports it both one-hot and as an index.
module moore_ssm_sched_rr_arbiter
   import moore_ssm_sched_pkg::*;
#(
   parameter int NREQ = 4,
   localparam int IDW = id_width(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  grant_idx,
   output logic            grant_any
);

   always_comb begin
      int idx;
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      idx       = 0;
      for (int i = 0; i < NREQ; i++) begin
         idx = int'(ptr) + i;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!grant_any && req[idx]) begin
            grant_any      = 1'b1;
            grant[idx]     = 1'b1;
            grant_idx      = IDW'(idx);
         end
      end
   end

endmodule

// File: rtl/moore_ssm_sched.sv
// Shares one 1101 Moore detector between NREQ producers: grants a word,
// clears the detector, shifts the word in MSB-first and returns the match count.
module moore_ssm_sched
   import moore_ssm_sched_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int CNTW  = 4,
   localparam int IDW  = id_width(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_data,
   output logic [NREQ-1:0]       req_ready,
   output logic                  det_x1,
   output logic                  det_clr_n,
   input  logic                  det_match,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [CNTW-1:0]       rsp_count
);

   localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   sched_state_t     state;
   logic [IDW-1:0]   rr_ptr;
   logic [WIDTH-1:0] shift_reg;
   logic [BCW-1:0]   bit_cnt;
   logic [CNTW-1:0]  match_cnt;

   logic [NREQ-1:0]  arb_req;
   logic [NREQ-1:0]  grant;
   logic [IDW-1:0]   grant_idx;
   logic             grant_any;
   logic [IDW-1:0]   next_ptr;
   logic             sample_en;

   assign arb_req = (state == ST_IDLE) ? req_valid : '0;

   moore_ssm_sched_rr_arbiter #(
      .NREQ(NREQ)
   ) u_arb (
      .req       (arb_req),
      .ptr       (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_any (grant_any)
   );

   // The accept strobe is the same-cycle handshake; held low while in reset.
   assign req_ready = rst_n ? grant : '0;
   assign next_ptr  = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);

   // The detector lags the serial bit by one clock, so the first shift cycle
   // only ever sees the cleared state and is skipped; DRAIN catches the last bit.
   assign sample_en = ((state == ST_SHIFT) && (bit_cnt != '0)) || (state == ST_DRAIN);

   assign rsp_count = match_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         rr_ptr    <= '0;
         shift_reg <= '0;
         bit_cnt   <= '0;
         match_cnt <= '0;
         det_x1    <= 1'b0;
         det_clr_n <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
      end else begin
         if (sample_en && det_match && (match_cnt != '1))
            match_cnt <= match_cnt + CNTW'(1);

         case (state)
            ST_IDLE: begin
               if (grant_any) begin
                  shift_reg <= req_data[int'(grant_idx)*WIDTH +: WIDTH];
                  rsp_id    <= grant_idx;
                  rr_ptr    <= next_ptr;
                  match_cnt <= '0;
                  det_clr_n <= 1'b0;
                  det_x1    <= 1'b0;
                  state     <= ST_CLEAR;
               end
            end
            ST_CLEAR: begin
               det_clr_n <= 1'b1;
               det_x1    <= shift_reg[WIDTH-1];
               shift_reg <= shift_reg << 1;
               bit_cnt   <= '0;
               state     <= ST_SHIFT;
            end
            ST_SHIFT: begin
               if (bit_cnt == BCW'(WIDTH - 1)) begin
                  det_x1 <= 1'b0;
                  state  <= ST_DRAIN;
               end else begin
                  det_x1    <= shift_reg[WIDTH-1];
                  shift_reg <= shift_reg << 1;
                  bit_cnt   <= bit_cnt + BCW'(1);
               end
            end
            ST_DRAIN: begin
               rsp_valid <= 1'b1;
               state     <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_moore_ssm_sched.sv
// Testbench for moore_ssm_sched with a behavioural 1101 Moore detector attached
// and a reference model that counts 1101 occurrences directly in each word.
module tb_moore_ssm_sched;

   localparam int NREQ  = 4;
   localparam int WIDTH = 8;
   localparam int CNTW  = 4;
   localparam int IDW   = 2;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*WIDTH-1:0] req_data;
   logic [NREQ-1:0]       req_ready;
   logic                  det_x1;
   logic                  det_clr_n;
   logic                  det_match;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [IDW-1:0]        rsp_id;
   logic [CNTW-1:0]       rsp_count;

   int n_checks = 0;
   int n_pass   = 0;
   int model_ptr = 0;

   always #5 clk = ~clk;

   moore_ssm_sched #(
      .NREQ(NREQ), .WIDTH(WIDTH), .CNTW(CNTW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .det_x1(det_x1), .det_clr_n(det_clr_n), .det_match(det_match),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_count(rsp_count)
   );

   // Stand-in for the shared detector: A,B,C,D track prefixes of 1101, E is the match.
   typedef enum logic [2:0] {DA, DB, DC, DD, DE} det_state_t;
   det_state_t det_state;

   always @(posedge clk or negedge rst_n or negedge det_clr_n) begin
      if (!rst_n || !det_clr_n) det_state <= DA;
      else begin
         case (det_state)
            DA:      det_state <= det_x1 ? DB : DA;
            DB:      det_state <= det_x1 ? DC : DA;
            DC:      det_state <= det_x1 ? DC : DD;
            DD:      det_state <= det_x1 ? DE : DA;
            default: det_state <= det_x1 ? DC : DA;
         endcase
      end
   end

   assign det_match = (det_state == DE);

   typedef struct {
      int               id;
      logic [WIDTH-1:0] word;
      int               exp_count;
   } vec_t;

   vec_t vecs[8];

   function automatic int ref_count(input logic [WIDTH-1:0] w);
      int c = 0;
      for (int p = 0; p <= WIDTH - 4; p++)
         if (w[WIDTH-1-p -: 4] == 4'b1101) c++;
      return c;
   endfunction

   function automatic int ref_grant(input logic [NREQ-1:0] v, input int ptr);
      for (int i = 0; i < NREQ; i++)
         if (v[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
      return -1;
   endfunction

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      req_data  = '0;
      rsp_ready = 1'b0;
      model_ptr = 0;
      repeat (3) @(negedge clk);
      check_output("reset req_ready", 32'(req_ready), 0);
      check_output("reset det_x1", 32'(det_x1), 0);
      check_output("reset det_clr_n", 32'(det_clr_n), 1);
      check_output("reset rsp_valid", 32'(rsp_valid), 0);
      check_output("reset rsp_id", 32'(rsp_id), 0);
      check_output("reset rsp_count", 32'(rsp_count), 0);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Called at a negedge; returns with g = granted index (or -1 on timeout).
   task automatic wait_grant(output int g);
      g = -1;
      for (int c = 0; c < 100; c++) begin
         #1;
         if (|req_ready) begin
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
            check_output("grant onehot", 32'($countones(req_ready)), 1);
            return;
         end
         @(negedge clk);
      end
      check_output("grant timeout", 0, 1);
   endtask

   // Called at the first negedge after the accept edge; cyc counts cycles since accept.
   task automatic wait_rsp(output int cyc);
      cyc = 1;
      while (!rsp_valid && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      if (!rsp_valid) check_output("rsp timeout", 0, 1);
   endtask

   task automatic apply_stimulus(input vec_t v);
      int g;
      int bad;
      @(negedge clk);
      req_data[v.id*WIDTH +: WIDTH] = v.word;
      req_valid[v.id] = 1'b1;
      rsp_ready = 1'b1;
      wait_grant(g);
      check_output("grant id", 32'(g), 32'(ref_grant(req_valid, model_ptr)));
      model_ptr = (g + 1) % NREQ;
      @(posedge clk);
      @(negedge clk);
      req_valid[v.id] = 1'b0;
      req_data[v.id*WIDTH +: WIDTH] = ~v.word;
      check_output("clear det_clr_n", 32'(det_clr_n), 0);
      check_output("clear det_x1", 32'(det_x1), 0);
      bad = 0;
      for (int k = 0; k < WIDTH; k++) begin
         @(negedge clk);
         if (det_x1 !== v.word[WIDTH-1-k] || det_clr_n !== 1'b1) bad++;
      end
      check_output("serial bits", 32'(bad), 0);
      @(negedge clk);
      check_output("drain rsp_valid", 32'(rsp_valid), 0);
      @(negedge clk);
      check_output("latency rsp_valid", 32'(rsp_valid), 1);
      check_output("rsp_id", 32'(rsp_id), 32'(v.id));
      check_output("rsp_count", 32'(rsp_count), 32'(v.exp_count));
      @(negedge clk);
      check_output("rsp dropped", 32'(rsp_valid), 0);
   endtask

   initial begin
      int g;
      int cyc;
      int bad;
      int rr_order[5]  = '{0, 1, 2, 3, 0};
      int rr_counts[5] = '{1, 2, 0, 2, 1};
      logic [WIDTH-1:0] rr_words[NREQ] = '{8'hD0, 8'h6D, 8'hFF, 8'hDB};
      logic [WIDTH-1:0] word;
      logic [NREQ-1:0]  mask;

      vecs[0] = '{0, 8'b11011011, 2};
      vecs[1] = '{0, 8'hFF, 0};
      vecs[2] = '{0, 8'h00, 0};
      vecs[3] = '{1, 8'b00000011, 0};
      vecs[4] = '{1, 8'b01000000, 0};
      vecs[5] = '{3, 8'h6D, 2};
      vecs[6] = '{2, 8'hD0, 1};
      vecs[7] = '{3, 8'b11011010, 2};

      do_reset();
      for (int i = 0; i < 8; i++) apply_stimulus(vecs[i]);

      // Round-robin with every requester continuously valid
      do_reset();
      for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = rr_words[i];
      req_valid = '1;
      rsp_ready = 1'b1;
      for (int n = 0; n < 5; n++) begin
         wait_grant(g);
         check_output("rr grant", 32'(g), 32'(rr_order[n]));
         @(posedge clk);
         @(negedge clk);
         wait_rsp(cyc);
         check_output("rr latency", 32'(cyc), 32'(WIDTH + 3));
         check_output("rr id", 32'(rsp_id), 32'(rr_order[n]));
         check_output("rr count", 32'(rsp_count), 32'(rr_counts[n]));
         if (n == 4) req_valid = '0;
         @(negedge clk);
      end
      model_ptr = 1;

      // Backpressure in RESP with another requester waiting
      @(negedge clk);
      rsp_ready = 1'b0;
      req_data[1*WIDTH +: WIDTH] = 8'hDB;
      req_valid[1] = 1'b1;
      wait_grant(g);
      check_output("bp grant", 32'(g), 1);
      @(posedge clk);
      @(negedge clk);
      req_valid[1] = 1'b0;
      req_data[3*WIDTH +: WIDTH] = 8'hD0;
      req_valid[3] = 1'b1;
      wait_rsp(cyc);
      bad = 0;
      for (int c = 0; c < 5; c++) begin
         if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_count !== 4'd2 || req_ready !== '0) bad++;
         @(negedge clk);
      end
      check_output("bp stable", 32'(bad), 0);
      rsp_ready = 1'b1;
      @(negedge clk);
      wait_grant(g);
      check_output("bp resume grant", 32'(g), 3);
      @(posedge clk);
      @(negedge clk);
      req_valid[3] = 1'b0;
      wait_rsp(cyc);
      check_output("bp resume count", 32'(rsp_count), 1);
      @(negedge clk);

      // Reset while shifting bit 3
      @(negedge clk);
      req_data[0*WIDTH +: WIDTH] = 8'hDB;
      req_valid[0] = 1'b1;
      wait_grant(g);
      @(posedge clk);
      @(negedge clk);
      req_valid[0] = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      req_valid[1] = 1'b1;
      #1;
      check_output("midrst req_ready", 32'(req_ready), 0);
      check_output("midrst det_x1", 32'(det_x1), 0);
      check_output("midrst det_clr_n", 32'(det_clr_n), 1);
      check_output("midrst rsp_valid", 32'(rsp_valid), 0);
      check_output("midrst rsp_id", 32'(rsp_id), 0);
      check_output("midrst rsp_count", 32'(rsp_count), 0);
      req_valid = '0;
      @(negedge clk);
      rst_n = 1'b1;
      model_ptr = 0;
      apply_stimulus(vecs[6]);

      // Random traffic against the reference model
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
         for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
         req_valid = mask;
         rsp_ready = 1'b0;
         wait_grant(g);
         check_output("rand grant", 32'(g), 32'(ref_grant(mask, model_ptr)));
         if (g < 0) break;
         model_ptr = (g + 1) % NREQ;
         word = req_data[g*WIDTH +: WIDTH];
         @(posedge clk);
         @(negedge clk);
         for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
         req_valid = NREQ'($urandom);
         wait_rsp(cyc);
         check_output("rand latency", 32'(cyc), 32'(WIDTH + 3));
         bad = 0;
         repeat ($urandom_range(0, 3)) begin
            if (rsp_valid !== 1'b1 || req_ready !== '0) bad++;
            @(negedge clk);
         end
         check_output("rand hold", 32'(bad), 0);
         check_output("rand id", 32'(rsp_id), 32'(g));
         check_output("rand count", 32'(rsp_count), 32'(ref_count(word)));
         req_valid = '0;
         rsp_ready = 1'b1;
         @(negedge clk);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/moore_ssm_sched.md
Name: moore_ssm_sched

Overview:
Round-robin scheduler that shares one 1101 Moore sequence detector (states A/B/C/D/E, match output high in state E) between NREQ word-producers.
- Grants one requester at a time and latches its WIDTH-bit word.
- Clears the detector, then shifts the word into the detector's serial input MSB-first, one bit per clock.
- Counts detector match cycles and returns the count, tagged with the requester id, on a valid/ready response port.
- Sits between the producer blocks and the detector instance at the top level.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, bits per word, serialized MSB-first (4..32)
CNTW, 4, match-count width; must satisfy 2^CNTW > WIDTH/3

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester word valid
req_data  in  NREQ*WIDTH  packed words; requester i occupies [i*WIDTH +: WIDTH]
req_ready  out  NREQ  one-hot accept strobe; at most one bit high per cycle
det_x1  out  1  registered serial bit to the detector x1 input
det_clr_n  out  1  registered active-low clear to the detector reset input
det_match  in  1  detector state-E flag (y[3]), synchronous to clk
rsp_valid  out  1  result valid
rsp_ready  in  1  result accepted
rsp_id  out  $clog2(NREQ)  requester index of the result
rsp_count  out  CNTW  number of matches found in the word

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - FSM enters IDLE; rr pointer = 0.
  - req_ready = 0, det_x1 = 0, det_clr_n = 1.
  - rsp_valid = 0, rsp_id = 0, rsp_count = 0.
- FSM states are IDLE, CLEAR, SHIFT, DRAIN and RESP.
- IDLE:
  - If any req_valid is high, grant the first valid requester at or after the rr pointer, searching upward with wrap.
  - Pulse req_ready[g] combinationally in this cycle. Handshake completes the same cycle.
  - Latch req_data[g] into the shift register, latch g into rsp_id, set rr pointer to g+1 mod NREQ, clear the count, go to CLEAR.
  - If no req_valid is high, stay in IDLE with all req_ready low.
- CLEAR (1 cycle):
  - det_clr_n = 0 and det_x1 = 0, both registered, so they are glitch-free at the detector's async reset pin.
  - Next state is SHIFT.
- SHIFT (WIDTH cycles):
  - det_clr_n = 1. det_x1 = shift-register MSB; shift left once per cycle.
  - A bit counter counts 0..WIDTH-1. Leave SHIFT after the last bit.
- Match sampling:
  - Bit k, presented in SHIFT cycle k, appears as a detector state change in cycle k+1.
  - Sample det_match in SHIFT cycles 2..WIDTH and in the single DRAIN cycle, i.e. exactly WIDTH samples.
  - Increment the count on each sample where det_match = 1. State E never persists two cycles, so each sample is one match.
  - The count saturates at all-ones; unreachable under the parameter rule.
- DRAIN (1 cycle): det_x1 = 0, take the final sample, go to RESP.
- RESP:
  - rsp_valid = 1 with rsp_id and rsp_count held stable.
  - On rsp_valid & rsp_ready, drop rsp_valid next cycle and return to IDLE.
  - No new grant is issued in the same cycle.
- Latency: accept at cycle t gives first rsp_valid at cycle t+3+WIDTH (t+11 for WIDTH=8) when rsp_ready is held high.
- Throughput: one word per WIDTH+4 cycles.
- Fairness: a continuously valid requester is granted within NREQ grants.
- Reset mid-operation: all state returns to reset values immediately.
  - det_clr_n stays high until the next CLEAR. The detector has its own reset on rst_n.
- req_data changes after the accept cycle have no effect.
- req_valid dropping without a grant is legal.

Decomposition:
- Shared package: FSM state encoding (IDLE, CLEAR, SHIFT, DRAIN, RESP) and a localparam for id width, $clog2(NREQ).
- One sub-module: rr_arbiter (NREQ request vector, rotating pointer, one-hot grant plus encoded index). FSM, shifter and counter stay in the top.
- The top-level testbench instantiates the existing detector and connects det_x1, det_clr_n and det_match, with det_match = y[3].

Test Plan:
- Single word: requester 0 sends 8'b11011011, rsp_ready=1 → rsp_id=0, rsp_count=2, rsp_valid exactly 11 cycles after accept.
- No match: 8'hFF, then 8'h00 → rsp_count=0 for both. det_x1 sequence matches the word MSB-first; det_clr_n is low exactly one cycle before each SHIFT.
- Round-robin: all 4 requesters valid continuously with words 8'hD0 / 8'h6D / 8'hFF / 8'hDB → grant order 0,1,2,3,0; counts 1,2,0,2.
- Backpressure: rsp_ready low for 5 cycles in RESP → rsp_valid, rsp_id and rsp_count stable, no req_ready pulses, FSM resumes after the handshake.
- Clear isolation: send 8'b00000011 then 8'b01000000 → second count = 0, i.e. no carry-over of detector state between words.
- Reset mid-SHIFT: assert rst_n low at SHIFT bit 3 → all outputs at reset values. After release, a fresh 8'hD0 from requester 2 returns count=1, id=2.
